// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: handshaked memory port feeding a small prefetch
// queue of {pc, instruction} pairs, with redirect flush and halt support.
module fetch_prefetch_unit #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH = 4,
   parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [WORD_SIZE-1:0]   imem_addr,
   input  logic                   imem_ready,
   input  logic [WORD_SIZE-1:0]   imem_rdata,
   input  logic                   redirect_valid,
   input  logic [WORD_SIZE-1:0]   redirect_pc,
   input  logic                   halt,
   output logic                   inst_valid,
   output logic [WORD_SIZE-1:0]   inst,
   output logic [WORD_SIZE-1:0]   inst_pc,
   input  logic                   inst_ready,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [WORD_SIZE-1:0]   fetch_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t               state;
   logic [WORD_SIZE-1:0] fetch_pc;
   logic [WORD_SIZE-1:0] pc_q [DEPTH];
   logic [WORD_SIZE-1:0] inst_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 fire;
   logic                 enq;

   assign imem_req   = (state == FETCH) || (state == DRAIN);
   assign inst_valid = (queue_count != '0);
   assign inst       = inst_q[rd_ptr];
   assign inst_pc    = pc_q[rd_ptr];
   assign fire       = inst_valid && inst_ready;
   assign enq        = (state == FETCH) && imem_ready && !redirect_valid;

   // Queue storage needs no reset; occupancy alone says which slots are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[wr_ptr]   <= imem_addr;
         inst_q[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         imem_addr   <= RESET_PC;
         fetch_pc    <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_count <= '0;
         fetch_count <= '0;
      end else begin
         if (fire)
            fetch_count <= fetch_count + 1'b1;

         // A redirect still counts a same-cycle fire, but wipes the queue.
         if (redirect_valid) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
         end else begin
            if (enq)
               wr_ptr <= wr_ptr + 1'b1;
            if (fire)
               rd_ptr <= rd_ptr + 1'b1;
            if (enq && !fire)
               queue_count <= queue_count + ONE_C;
            else if (!enq && fire)
               queue_count <= queue_count - ONE_C;
         end

         // Space checks use the pre-edge count and ignore a same-edge fire,
         // so an issued request always has a free slot for its response.
         case (state)
            IDLE: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
               end else if (!halt && (queue_count < DEPTH_C)) begin
                  state     <= FETCH;
                  imem_addr <= fetch_pc;
               end
            end
            FETCH: begin
               if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
                  state    <= imem_ready ? IDLE : DRAIN;
               end else if (imem_ready) begin
                  fetch_pc <= imem_addr + 1'b1;
                  if (!halt && (queue_count < (DEPTH_C - ONE_C)))
                     imem_addr <= imem_addr + 1'b1;
                  else
                     state <= IDLE;
               end
            end
            DRAIN: begin
               if (redirect_valid)
                  fetch_pc <= redirect_pc;
               if (imem_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   occupancy_bound: assert property (@(posedge clk) disable iff (reset) queue_count <= DEPTH_C);

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined datapath.
- Replaces the direct "PC drives instruction-memory address" fetch with a handshaked memory port and a DEPTH-entry prefetch queue of {pc, instruction} pairs.
- Handles branch/jump redirects by flushing the queue and dropping in-flight responses.
- Feeds the IF/ID register through a valid/ready handshake, supports halt, and counts delivered instructions.

Parameters:
- WORD_SIZE, 16, width of PC and instruction words (word-addressed memory, PC increment = 1)
- DEPTH, 4, prefetch queue entries (power of two, >= 2)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; held high until imem_ready
- imem_addr  output  WORD_SIZE  fetch address; stable while imem_req high
- imem_ready  input  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  input  WORD_SIZE  instruction word, valid when imem_req && imem_ready
- redirect_valid  input  1  one-cycle pulse: taken branch/jump/exception
- redirect_pc  input  WORD_SIZE  new fetch PC, sampled when redirect_valid
- halt  input  1  level: no new requests issued while high
- inst_valid  output  1  queue head valid
- inst  output  WORD_SIZE  queue head instruction
- inst_pc  output  WORD_SIZE  PC of queue head
- inst_ready  input  1  decode accepts head; fire = inst_valid && inst_ready
- queue_count  output  clog2(DEPTH)+1  current occupancy
- fetch_count  output  WORD_SIZE  number of fires since reset, wraps modulo 2^WORD_SIZE

Behaviour:
- Reset (async, any time including mid-request):
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - Queue empty, inst_valid=0, queue_count=0, fetch_count=0, state=IDLE.
  - An in-flight memory transaction is abandoned.
- All outputs registered except inst/inst_pc/inst_valid, which are decoded from the queue head registers; no comb path from any input to any output.
- States IDLE, FETCH, DRAIN. imem_req = (state==FETCH || state==DRAIN).
- Space condition: queue_count + (1 if response pending) < DEPTH.
  - IDLE -> FETCH when !halt && !redirect_valid && space; imem_addr=fetch_pc.
  - FETCH, imem_ready, no redirect:
    - enqueue {imem_addr, imem_rdata}; fetch_pc = imem_addr+1 (wraps).
    - Stay FETCH with next address if !halt and space after this edge, else IDLE.
    - Zero-wait memory gives 1 instruction/cycle.
  - FETCH, redirect_valid && imem_ready: response discarded; fetch_pc=redirect_pc; -> IDLE.
  - FETCH, redirect_valid && !imem_ready: fetch_pc=redirect_pc; -> DRAIN; imem_addr unchanged.
  - DRAIN: imem_ready -> IDLE, response discarded. A further redirect updates fetch_pc only (last wins).
  - halt never aborts an issued request; the response is enqueued normally.
- Latency:
  - Reset release -> imem_req high after the first rising edge.
  - Response accepted at edge N -> inst_valid at cycle N+1 if queue was empty.
- Redirect:
  - At the edge, the queue is flushed: count=0, inst_valid=0 next cycle.
  - The first new request is issued the cycle after IDLE is reached.
  - A fire in the same cycle as redirect_valid is counted (fetch_count+1), then the queue is flushed.
- Simultaneous enqueue and fire, no redirect:
  - count unchanged; legal when full (the fire frees the slot at the same edge).
  - The space check uses pre-edge count, so no request is issued that would overflow.
- Full: no request issued; inst_valid stays 1.
- Empty: inst_valid=0; inst/inst_pc don't-care.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH (assertion).

Test Plan:
- Reset, zero-wait memory returning mem[a]=0x1000+a, inst_ready=1 -> fires PC 0,1,2,... with inst 0x1000,0x1001,...; one per cycle after a 2-cycle start-up; fetch_count=10 after 10 fires.
- inst_ready=0, DEPTH=4 -> exactly 4 requests complete, queue_count=4, imem_req=0. Raise inst_ready -> fires PC 0..3 in order, then fetching resumes at PC 4.
- Memory with 3-cycle wait, redirect_pc=0x0040 pulsed one cycle after request for PC 2 issued -> imem_addr held at 2 until ready, response dropped, next request addr=0x0040, first delivered inst_pc=0x0040, no PC 2 delivered.
- Redirect to 0x0080 coincident with imem_ready and with a fire of PC 5 -> fetch_count increments by 1, queue empty next cycle, next request addr=0x0080.
- halt raised while request for PC 7 outstanding -> PC 7 enqueued, no further imem_req; deassert halt -> next request addr=8.
- Reset asserted mid-DRAIN -> all outputs at reset values asynchronously; after release, first request addr=RESET_PC. With RESET_PC=0xFFFF, second request addr=0x0000 (wrap).
